// File: rtl/twos_comp_sequencer.sv
// Bit-serial two's-complement negate/add/subtract/increment using one shared full adder.
// Optional abort input enabled by defining TWOS_SEQ_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for an operation, start_ready=1
// RUN   | one result bit per cycle through the shared adder
// DONE  | result held until the consumer takes it
module twos_comp_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef TWOS_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] eff_a_q, eff_a_d;
  logic [WIDTH-1:0] eff_b_q, eff_b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             done_valid_q, done_valid_d;
  logic             sum_bit, carry_new, abort_hit;

`ifdef TWOS_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    eff_a_d      = eff_a_q;
    eff_b_d      = eff_b_q;
    carry_d      = carry_q;
    result_d     = result_q;
    carry_out_d  = carry_out_q;
    overflow_d   = overflow_q;
    done_valid_d = done_valid_q;
    sum_bit      = eff_a_q[idx_q] ^ eff_b_q[idx_q] ^ carry_q;
    carry_new    = (eff_a_q[idx_q] & eff_b_q[idx_q]) |
                   (carry_q & (eff_a_q[idx_q] ^ eff_b_q[idx_q]));
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          eff_a_d = (op == 2'b00) ? ~a : a;
          case (op)
            2'b01:   eff_b_d = b;
            2'b10:   eff_b_d = ~b;
            default: eff_b_d = '0;
          endcase
          carry_d = (op != 2'b01);
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q] = sum_bit;
        carry_d         = carry_new;
        if (idx_q == IW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB
          carry_out_d  = carry_new;
          overflow_d   = carry_q ^ carry_new;
          done_valid_d = 1'b1;
          state_d      = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (done_ready) begin
          done_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_hit && (state_q != IDLE)) begin
      state_d      = IDLE;
      done_valid_d = 1'b0;
      result_d     = '0;
      carry_out_d  = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      eff_a_q      <= '0;
      eff_b_q      <= '0;
      carry_q      <= 1'b0;
      result_q     <= '0;
      carry_out_q  <= 1'b0;
      overflow_q   <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      eff_a_q      <= eff_a_d;
      eff_b_q      <= eff_b_d;
      carry_q      <= carry_d;
      result_q     <= result_d;
      carry_out_q  <= carry_out_d;
      overflow_q   <= overflow_d;
      done_valid_q <= done_valid_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = done_valid_q;
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_twos_comp_sequencer.sv
// Directed bench for twos_comp_sequencer (WIDTH=4); abort scenario runs when TWOS_SEQ_ABORT_EN is defined.
module tb_twos_comp_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [1:0] op = 2'b00;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic [3:0] result;
  logic       carry_out;
  logic       overflow;
`ifdef TWOS_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  twos_comp_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .a(a), .b(b),
`ifdef TWOS_SEQ_ABORT_EN
    .abort(abort),
`endif
    .done_valid(done_valid), .done_ready(done_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for done (bounded), check latency and results, then hand it off.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] av,
                        input logic [3:0] bv, input logic [3:0] er, input logic ec,
                        input logic eo);
    int cyc;
    chk({tag, "_ready_before"}, 32'(start_ready), 32'd1);
    op = o; a = av; b = bv; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    chk({tag, "_ready_run"}, 32'(start_ready), 32'd0);
    cyc = 0;
    while (!done_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd4);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_carry"}, 32'(carry_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk({tag, "_done_drop"}, 32'(done_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [3:0] held_r;
    #12;
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();

    run_op("neg3",  2'b00, 4'b0011, 4'b1010, 4'b1101, 1'b0, 1'b0);
    run_op("neg0",  2'b00, 4'b0000, 4'b0110, 4'b0000, 1'b1, 1'b0);
    run_op("neg8",  2'b00, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1);
    run_op("add71", 2'b01, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
    run_op("sub53", 2'b10, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0);
    run_op("inc5",  2'b11, 4'b0101, 4'b1111, 4'b0110, 1'b0, 1'b0);

    // Backpressure: add 0010+0011 = 0101, with stray start_valid pulses in RUN and DONE
    op = 2'b01; a = 4'b0010; b = 4'b0011; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    start_valid = 1'b1; a = 4'b1111; b = 4'b1111;
    step();
    start_valid = 1'b0;
    chk("bp_ready_run", 32'(start_ready), 32'd0);
    cyc = 0;
    while (!done_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("bp_done_seen", 32'(done_valid), 32'd1);
    chk("bp_result", 32'(result), 32'b0101);
    held_r = result;
    for (int i = 0; i < 3; i++) begin
      start_valid = (i == 1);
      step();
      chk("bp_hold_valid", 32'(done_valid), 32'd1);
      chk("bp_hold_result", 32'(result), 32'(held_r));
      chk("bp_hold_carry", 32'(carry_out), 32'd0);
      chk("bp_hold_ovf", 32'(overflow), 32'd0);
      chk("bp_hold_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk("bp_done_drop", 32'(done_valid), 32'd0);
    chk("bp_ready_rise", 32'(start_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_no_queue_valid", 32'(done_valid), 32'd0);
      chk("bp_no_queue_ready", 32'(start_ready), 32'd1);
    end

    // Throughput with done_ready held high: start_ready returns WIDTH+1 edges after accept
    done_ready = 1'b1;
    op = 2'b11; a = 4'b0001; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    cyc = 0;
    while (!start_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk("tput_cycles", 32'(cyc), 32'd5);
    done_ready = 1'b0;

    // Reset mid-RUN after 2 RUN cycles; prior result is nonzero (0010)
    run_op("pre_rst", 2'b01, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0);
    op = 2'b01; a = 4'b0111; b = 4'b0001; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_start_ready", 32'(start_ready), 32'd1);
    chk("mrst_done_valid", 32'(done_valid), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_carry", 32'(carry_out), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mrst_no_done", 32'(done_valid), 32'd0);
    end
    run_op("inc15", 2'b11, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);

`ifdef TWOS_SEQ_ABORT_EN
    op = 2'b01; a = 4'b0011; b = 4'b0100; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ready", 32'(start_ready), 32'd1);
    chk("abort_done_valid", 32'(done_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort_no_done", 32'(done_valid), 32'd0);
    end
    run_op("post_abort", 2'b10, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
